ascii_bin_parser: RTL
=====================

ASCII_BIN_PARSER -- requirements
Module: ascii_bin_parser

Interface
REQ-001 SHALL have parameter DIGITS, default 7: number of ASCII digit characters per frame, equal to the width of bin_out.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port char_in, input, 8: ASCII character presented by the upstream source.
REQ-005 SHALL have port char_valid, input, 1: char_in is valid this cycle.
REQ-006 SHALL have port char_ready, output, 1: parser accepts a character this cycle.
REQ-007 SHALL have port bin_out, output, DIGITS: parsed binary value.
REQ-008 SHALL have port bin_valid, output, 1: bin_out holds a complete frame.
REQ-009 SHALL have port bin_ready, input, 1: downstream consumes bin_out.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on a frame error.
REQ-011 SHALL have port err_count, output, 8: saturating count of frame errors.

Function
REQ-012 SHALL accept a character only on a cycle where char_valid and char_ready are both 1.
REQ-013 SHALL treat 8'h30 ('0') as bit 0 and 8'h31 ('1') as bit 1; every other byte is invalid.
REQ-014 SHALL receive digits MSB first: the first accepted digit lands in bin_out[DIGITS-1] and the last in bin_out[0].
REQ-015 SHALL implement states IDLE (count=0), COLLECT (0<count<DIGITS), TERM (TERM only with the macro; see REQ-027) and OUTPUT.
REQ-016 SHALL go IDLE->COLLECT on an accepted valid digit, and shift that digit into a shift register.
REQ-017 SHALL move from COLLECT to OUTPUT on the accepted DIGITS-th digit, when the macro is absent.
REQ-018 SHALL drive char_ready=1 in IDLE, COLLECT and TERM, and 0 in OUTPUT, decoded combinationally from the state.
REQ-019 SHALL assert bin_valid in the cycle after the frame-completing character is accepted (latency 1), and hold bin_out stable until bin_valid and bin_ready are both 1.
REQ-020 SHALL return to IDLE on the cycle bin_valid and bin_ready are both 1; bin_out keeps its last value and bin_valid drops to 0.
REQ-021 SHALL respond to an invalid character accepted in IDLE, COLLECT or TERM as follows: pulse err for exactly one cycle (the cycle after acceptance), discard the partial frame, return to IDLE and clear count.
REQ-022 SHALL increment err_count once per err pulse and saturate at 8'hFF with no wrap-around.
REQ-023 SHALL keep bin_valid=0 for any frame that errors; a partial frame is never emitted.
REQ-024 SHALL let the character after an error start a new frame, with no resynchronisation gap.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: state=IDLE, count=0, shift register=0, bin_out=0, bin_valid=0, err=0, err_count=0; char_ready is then 1.
REQ-026 SHALL discard any partial or pending frame on reset mid-operation; no bin_valid or err follows the release of reset.

Configuration
REQ-027 SHALL use macro ASCII_PARSE_TERM_EN; when defined, the accepted DIGITS-th digit moves COLLECT->TERM instead of OUTPUT.
REQ-028 SHALL, with the macro defined: in TERM, an accepted 8'h0A (LF) moves to OUTPUT (bin_valid the next cycle); any other accepted byte, including a digit, is a frame error per REQ-021.
REQ-029 SHALL, with the macro defined, treat an LF received in IDLE or COLLECT as a frame error, since the frame is short.
REQ-030 SHALL, without the macro, have no TERM state and treat LF as an ordinary invalid character.

Verification
REQ-031 SHALL check a basic frame: chars 31 30 31 30 30 31 31 back-to-back, bin_ready=1 -> bin_out=7'h53, bin_valid for 1 cycle, one cycle after the last char (with macro: after a trailing 0A).
REQ-032 SHALL check backpressure: frame 31x7 with bin_ready=0 for 5 cycles -> bin_valid and bin_out=7'h7F held, char_ready=0 throughout; release -> IDLE, char_ready=1.
REQ-033 SHALL check error recovery: chars 31 30 41, then 30x7 -> err pulses once after 41, err_count=1, then bin_out=7'h00 valid with no second err.
REQ-034 SHALL check saturation: 260 invalid chars (e.g. 20) -> err_count=8'hFF, no wrap.
REQ-035 SHALL check reset mid-frame: 4 digits, then rst_n low 2 cycles, then 7 digits 30 -> only one bin_valid, bin_out=7'h00, err_count=0.
REQ-036 SHALL check the terminator (macro only): 31x7 then 31 -> err pulse, no bin_valid; 30x3 then 0A -> err pulse, err_count=2.

Source files
------------

// File: rtl/ascii_bin_parser_if.sv
// Handshake bundle for ascii_bin_parser: a character stream in, a binary
// frame out, plus the error pulse and the error counter.
// master: the upstream/downstream side; slave: the parser itself.
interface ascii_bin_parser_if #(
    parameter int DIGITS = 7
);
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic [DIGITS-1:0] bin_out;
    logic              bin_valid;
    logic              bin_ready;
    logic              err;
    logic [7:0]        err_count;

    modport master (
        output char_in, char_valid, bin_ready,
        input  char_ready, bin_out, bin_valid, err, err_count
    );

    modport slave (
        input  char_in, char_valid, bin_ready,
        output char_ready, bin_out, bin_valid, err, err_count
    );
endinterface

// File: rtl/ascii_bin_parser.sv
// ascii_bin_parser: collects DIGITS ASCII '0'/'1' characters (MSB first)
// into a binary word and presents it with a valid/ready handshake.
// Any other byte aborts the frame with a one-cycle err pulse.
// Optional feature macro ASCII_PARSE_TERM_EN: when defined, a full frame
// must be followed by LF (8'h0A) before it is emitted.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no digits held, waiting for the first digit
// COLLECT | 0 < count < DIGITS digits held
// TERM    | all digits held, waiting for LF (only with the macro)
// OUTPUT  | bin_out valid, waiting for bin_ready; input stalled
module ascii_bin_parser #(
    parameter int DIGITS = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    ascii_bin_parser_if.slave  bus
);
    localparam int CW = $clog2(DIGITS + 1);

`ifdef ASCII_PARSE_TERM_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2,
        S_TERM    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;
`endif

    state_t            state, state_nx;
    logic [CW-1:0]     count, count_nx, count_inc;
    logic [DIGITS-1:0] shift, shift_nx, shift_sh, load_val, bin_out_q;
    logic              load, err_nx, err_q;
    logic [7:0]        err_cnt_q;
    logic              char_ready, accept, is_digit;

    // Ready is a pure state decode so upstream never waits on data paths.
    assign char_ready = (state != S_OUTPUT);
    assign accept     = bus.char_valid & char_ready;
    assign is_digit   = (bus.char_in[7:1] == 7'b0011000);
    assign shift_sh   = (shift << 1) | DIGITS'(bus.char_in[0]);
    assign count_inc  = count + 1'b1;

    assign bus.char_ready = char_ready;
    assign bus.bin_valid  = (state == S_OUTPUT);
    assign bus.bin_out    = bin_out_q;
    assign bus.err        = err_q;
    assign bus.err_count  = err_cnt_q;

    // Next-state, shift register and frame-load decisions.
    always_comb begin
        state_nx = state;
        count_nx = count;
        shift_nx = shift;
        load     = 1'b0;
        load_val = shift_sh;
        err_nx   = 1'b0;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (accept) begin
                    if (is_digit) begin
                        shift_nx = shift_sh;
                        if (count_inc == CW'(DIGITS)) begin
                            count_nx = '0;
`ifdef ASCII_PARSE_TERM_EN
                            state_nx = S_TERM;
`else
                            state_nx = S_OUTPUT;
                            load     = 1'b1;
`endif
                        end else begin
                            count_nx = count_inc;
                            state_nx = S_COLLECT;
                        end
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = S_IDLE;
                        count_nx = '0;
                        shift_nx = '0;
                    end
                end
            end
`ifdef ASCII_PARSE_TERM_EN
            S_TERM: begin
                if (accept) begin
                    if (bus.char_in == 8'h0A) begin
                        state_nx = S_OUTPUT;
                        load     = 1'b1;
                        load_val = shift;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = S_IDLE;
                        count_nx = '0;
                        shift_nx = '0;
                    end
                end
            end
`endif
            S_OUTPUT: begin
                if (bus.bin_ready) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                count_nx = '0;
                shift_nx = '0;
            end
        endcase
    end

    // State, datapath and saturating error counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            shift     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state <= state_nx;
            count <= count_nx;
            shift <= shift_nx;
            err_q <= err_nx;
            if (load) bin_out_q <= load_val;
            if (err_nx && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'h01;
        end
    end
endmodule
